// File: rtl/wshb_if.sv
// Wishbone bundle between the mire pattern writer and the SDRAM frame-buffer controller.
interface wshb_if;
  logic [31:0] adr;
  logic [15:0] dat_ms;
  logic [15:0] dat_sm;
  logic [1:0]  sel;
  logic        cyc;
  logic        stb;
  logic        we;
  logic        ack;
  logic [2:0]  cti;
  logic [1:0]  bte;

  modport master (
    output adr, dat_ms, sel, cyc, stb, we, cti, bte,
    input  ack, dat_sm
  );

  modport slave (
    input  adr, dat_ms, sel, cyc, stb, we, cti, bte,
    output ack, dat_sm
  );
endinterface

// File: rtl/vga_mire_writer.sv
// Writes a scrolling 8x8 checkerboard (RGB565) into the SDRAM frame buffer over Wishbone,
// in fixed-length bursts separated by short idle gaps so other masters can get the bus.
module vga_mire_writer #(
  parameter int unsigned vga_HDISP = 640,
  parameter int unsigned vga_VDISP = 480,
  parameter int unsigned BURST     = 64,
  parameter int unsigned PAUSE     = 2
) (
  input  logic   CLK,
  input  logic   RST,
  input  logic   EN,
  output logic   frame_done,
  wshb_if.master wshb_ifm
);

  localparam int unsigned XW = (vga_HDISP > 1) ? $clog2(vga_HDISP) : 1;
  localparam int unsigned YW = (vga_VDISP > 1) ? $clog2(vga_VDISP) : 1;
  localparam int unsigned BW = (BURST > 1) ? $clog2(BURST) : 1;

  localparam logic [XW-1:0] X_LAST = XW'(vga_HDISP - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(vga_VDISP - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BURST - 1);
  localparam logic [3:0]    P_LAST = 4'(PAUSE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_PAUSE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0]    f;
  logic [BW-1:0] b;
  logic [3:0]    p_cnt;
  logic [31:0]   adr_q;

  logic          bus_on;
  logic          wr_done;
  logic          x_last;
  logic          y_last;
  logic          b_last;
  logic          p_last;
  logic [10:0]   xf_sum;
  logic [10:0]   y_ext;
  logic          unused_dat_sm;

  assign bus_on  = (state == ST_WRITE);
  assign wr_done = bus_on && wshb_ifm.ack;
  assign x_last  = (x == X_LAST);
  assign y_last  = (y == Y_LAST);
  assign b_last  = (b == B_LAST);
  assign p_last  = (p_cnt == P_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (EN) state_nxt = ST_WRITE;
      ST_WRITE: if (wr_done && b_last) state_nxt = ST_PAUSE;
      ST_PAUSE: if (p_last) state_nxt = EN ? ST_WRITE : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Byte address is tracked incrementally (+2 per pixel) instead of computing
  // 2*(HDISP*Y+X); row-major order makes the two identical.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x          <= '0;
      y          <= '0;
      f          <= '0;
      b          <= '0;
      p_cnt      <= '0;
      adr_q      <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == ST_PAUSE) p_cnt <= p_cnt + 4'd1;
      else                   p_cnt <= '0;
      if (wr_done) begin
        b <= b_last ? '0 : b + 1'b1;
        if (x_last) begin
          x <= '0;
          if (y_last) begin
            y          <= '0;
            b          <= '0;
            f          <= f + 8'd1;
            adr_q      <= '0;
            frame_done <= 1'b1;
          end else begin
            y     <= y + 1'b1;
            adr_q <= adr_q + 32'd2;
          end
        end else begin
          x     <= x + 1'b1;
          adr_q <= adr_q + 32'd2;
        end
      end
    end
  end

  // Pattern phase: 11-bit X+F keeps the horizontal scroll from spilling into Y.
  always_comb begin
    xf_sum = 11'(x) + 11'(f);
    y_ext  = 11'(y);
  end

  assign wshb_ifm.adr    = adr_q;
  assign wshb_ifm.dat_ms = (xf_sum[3] ^ y_ext[3]) ? 16'hFFFF : 16'h0000;
  assign wshb_ifm.sel    = 2'b11;
  assign wshb_ifm.cti    = '0;
  assign wshb_ifm.bte    = '0;
  assign wshb_ifm.cyc    = bus_on;
  assign wshb_ifm.stb    = bus_on;
  assign wshb_ifm.we     = bus_on;

  assign unused_dat_sm = ^wshb_ifm.dat_sm;

endmodule

// File: tb/tb_vga_mire_writer.sv
// Self-checking bench for vga_mire_writer: randomized ack stimulus against a pixel-index reference model.
module tb_vga_mire_writer;

  localparam int unsigned H     = 640;
  localparam int unsigned V     = 16;
  localparam int unsigned BL    = 64;
  localparam int unsigned PS    = 2;
  localparam int unsigned FRAME = H * V;

  logic CLK = 1'b0;
  logic RST;
  logic EN;
  logic frame_done;

  wshb_if wshb ();

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference model: linear pixel index, frame number, acks in current tenure,
  // remaining idle gap cycles, bus-owned flag, expected frame_done.
  int unsigned m_n;
  int unsigned m_f;
  int unsigned m_b;
  int unsigned m_pause;
  bit          m_tenure;
  bit          m_fd;

  always #5 CLK = ~CLK;

  vga_mire_writer #(
    .vga_HDISP(H),
    .vga_VDISP(V),
    .BURST    (BL),
    .PAUSE    (PS)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .frame_done(frame_done),
    .wshb_ifm  (wshb)
  );

  function automatic logic [31:0] exp_adr(input int unsigned n);
    return 32'(2 * n);
  endfunction

  function automatic logic [15:0] exp_dat(input int unsigned n, input int unsigned f);
    int unsigned px, py;
    px = n % H;
    py = n / H;
    return ((((px + f) / 8) % 2) != ((py / 8) % 2)) ? 16'hFFFF : 16'h0000;
  endfunction

  task automatic model_reset();
    m_n = 0; m_f = 0; m_b = 0; m_pause = 0; m_tenure = 0; m_fd = 0;
  endtask

  task automatic model_edge(input bit ack_in, input bit en_in);
    m_fd = 0;
    if (m_tenure) begin
      if (ack_in) begin
        m_n++;
        m_b++;
        if (m_n == FRAME) begin
          m_n = 0;
          m_f = (m_f + 1) % 256;
          m_fd = 1;
        end
        if (m_b == BL) begin
          m_b = 0;
          m_tenure = 0;
          m_pause = PS;
        end
        if (m_fd) m_b = 0;
      end
    end else if (m_pause > 0) begin
      m_pause--;
      if (m_pause == 0) m_tenure = en_in;
    end else begin
      m_tenure = en_in;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b0; wshb.ack = 1'b0; wshb.dat_sm = 16'($urandom);
    model_reset();
    repeat (2) @(negedge CLK);
    n_tests++;
    if ({wshb.cyc, wshb.stb, wshb.we, frame_done} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: cyc/stb/we/fd=%b%b%b%b want 0000", wshb.cyc, wshb.stb, wshb.we, frame_done);
    end
    n_tests++;
    if (wshb.adr !== 32'd0 || wshb.dat_ms !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_data: adr=%0d dat=%h want 0 0000", wshb.adr, wshb.dat_ms);
    end
    n_tests++;
    if ({wshb.sel, wshb.cti, wshb.bte} !== {2'b11, 3'b000, 2'b00}) begin
      n_fail++;
      $display("FAIL const_fields: sel=%b cti=%b bte=%b want 11 000 00", wshb.sel, wshb.cti, wshb.bte);
    end
    EN = 1'b1; wshb.ack = 1'b1;
    @(negedge CLK);
    n_tests++;
    if (wshb.cyc !== 1'b0 || wshb.adr !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hold: cyc=%b adr=%0d want 0 0", wshb.cyc, wshb.adr);
    end
  endtask

  task automatic test_startup();
    @(negedge CLK);
    RST = 1'b0; EN = 1'b1; wshb.ack = 1'b1;
    model_reset();
    for (int unsigned i = 0; i < 68; i++) begin
      if (i != 0) @(negedge CLK);
      n_tests++;
      if ({wshb.cyc, wshb.stb, wshb.we, frame_done} !== {m_tenure, m_tenure, m_tenure, m_fd}) begin
        n_fail++;
        $display("FAIL startup_ctrl@%0d: cyc/stb/we/fd=%b%b%b%b want %b%b%b%b", i,
                 wshb.cyc, wshb.stb, wshb.we, frame_done, m_tenure, m_tenure, m_tenure, m_fd);
      end
      if (m_tenure) begin
        n_tests++;
        if (wshb.adr !== exp_adr(m_n) || wshb.dat_ms !== exp_dat(m_n, m_f)) begin
          n_fail++;
          $display("FAIL startup_data@%0d: adr=%0d dat=%h want %0d %h", i, wshb.adr, wshb.dat_ms,
                   exp_adr(m_n), exp_dat(m_n, m_f));
        end
      end
      if (i == 0 || i == 65 || i == 66) begin
        n_tests++;
        if (wshb.cyc !== 1'b0) begin
          n_fail++;
          $display("FAIL startup_gap@%0d: cyc=%b want 0", i, wshb.cyc);
        end
      end
      if (i == 1) begin
        n_tests++;
        if (wshb.cyc !== 1'b1 || wshb.adr !== 32'd0 || wshb.dat_ms !== 16'h0000) begin
          n_fail++;
          $display("FAIL first_write: cyc=%b adr=%0d dat=%h want 1 0 0000", wshb.cyc, wshb.adr, wshb.dat_ms);
        end
      end
      if (i == 9) begin
        n_tests++;
        if (wshb.adr !== 32'd16 || wshb.dat_ms !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL x8_write: adr=%0d dat=%h want 16 ffff", wshb.adr, wshb.dat_ms);
        end
      end
      if (i == 67) begin
        n_tests++;
        if (wshb.cyc !== 1'b1 || wshb.adr !== 32'd128) begin
          n_fail++;
          $display("FAIL second_burst: cyc=%b adr=%0d want 1 128", wshb.cyc, wshb.adr);
        end
      end
      model_edge(1'b1, 1'b1);
    end
  endtask

  task automatic test_ack_stall();
    int unsigned stall_left = 0;
    int unsigned post = 0;
    int unsigned hold_n = 0;
    bit stalled = 0;
    bit ack_v;
    for (int unsigned c = 0; c < 300; c++) begin
      @(negedge CLK);
      n_tests++;
      if ({wshb.cyc, wshb.stb, wshb.we, frame_done} !== {m_tenure, m_tenure, m_tenure, m_fd}) begin
        n_fail++;
        $display("FAIL stall_ctrl: cyc/stb/we/fd=%b%b%b%b want %b%b%b%b",
                 wshb.cyc, wshb.stb, wshb.we, frame_done, m_tenure, m_tenure, m_tenure, m_fd);
      end
      if (m_tenure) begin
        n_tests++;
        if (wshb.adr !== exp_adr(m_n) || wshb.dat_ms !== exp_dat(m_n, m_f)) begin
          n_fail++;
          $display("FAIL stall_data: adr=%0d dat=%h want %0d %h", wshb.adr, wshb.dat_ms,
                   exp_adr(m_n), exp_dat(m_n, m_f));
        end
      end
      if (!stalled && m_tenure && m_b == 20) begin
        stalled = 1; stall_left = 6; hold_n = m_n;
      end
      ack_v = 1'b1;
      if (stall_left > 0) begin
        n_tests++;
        if (wshb.cyc !== 1'b1 || wshb.stb !== 1'b1 || wshb.adr !== exp_adr(hold_n) ||
            wshb.dat_ms !== exp_dat(hold_n, m_f)) begin
          n_fail++;
          $display("FAIL stall_hold: cyc=%b stb=%b adr=%0d dat=%h want 1 1 %0d %h", wshb.cyc, wshb.stb,
                   wshb.adr, wshb.dat_ms, exp_adr(hold_n), exp_dat(hold_n, m_f));
        end
        ack_v = (stall_left == 1);
        stall_left--;
      end else if (stalled) begin
        post++;
        if (post == 1) begin
          n_tests++;
          if (wshb.adr !== exp_adr(hold_n + 1)) begin
            n_fail++;
            $display("FAIL stall_resume: adr=%0d want %0d", wshb.adr, exp_adr(hold_n + 1));
          end
        end
      end
      wshb.ack = ack_v;
      model_edge(ack_v, 1'b1);
      if (post >= 4) break;
    end
    if (post < 4) begin
      n_tests++; n_fail++;
      $display("FAIL stall_timeout: post=%0d want 4", post);
    end
  endtask

  task automatic test_random_frame();
    bit ack_v;
    bit done = 0;
    bit seen_fd = 0;
    for (int unsigned c = 0; c < 40000; c++) begin
      @(negedge CLK);
      n_tests++;
      if ({wshb.cyc, wshb.stb, wshb.we, frame_done} !== {m_tenure, m_tenure, m_tenure, m_fd}) begin
        n_fail++;
        $display("FAIL rand_ctrl@%0d: cyc/stb/we/fd=%b%b%b%b want %b%b%b%b", c,
                 wshb.cyc, wshb.stb, wshb.we, frame_done, m_tenure, m_tenure, m_tenure, m_fd);
      end
      if (m_tenure) begin
        n_tests++;
        if (wshb.adr !== exp_adr(m_n) || wshb.dat_ms !== exp_dat(m_n, m_f)) begin
          n_fail++;
          $display("FAIL rand_data@%0d: adr=%0d dat=%h want %0d %h", c, wshb.adr, wshb.dat_ms,
                   exp_adr(m_n), exp_dat(m_n, m_f));
        end
      end
      if (m_tenure && m_f == 0 && m_n == H) begin
        n_tests++;
        if (wshb.adr !== 32'd1280) begin
          n_fail++;
          $display("FAIL line_wrap: adr=%0d want 1280", wshb.adr);
        end
      end
      if (m_fd) begin
        seen_fd = 1;
        n_tests++;
        if (wshb.adr !== 32'd0 || frame_done !== 1'b1) begin
          n_fail++;
          $display("FAIL frame_wrap: adr=%0d fd=%b want 0 1", wshb.adr, frame_done);
        end
      end
      if (m_tenure && seen_fd && m_f == 1 && m_n == 7) begin
        done = 1;
        n_tests++;
        if (wshb.dat_ms !== 16'hFFFF) begin
          n_fail++;
          $display("FAIL frame1_x7: dat=%h want ffff", wshb.dat_ms);
        end
      end
      ack_v = ($urandom_range(0, 3) != 0);
      wshb.ack = ack_v;
      model_edge(ack_v, 1'b1);
      if (done) break;
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL rand_timeout: frame=%0d idx=%0d want frame 1 idx 7", m_f, m_n);
    end
  endtask

  task automatic test_en_drop();
    int unsigned phase = 0;
    int unsigned cnt = 0;
    int unsigned writes = 0;
    int unsigned lows = 0;
    int unsigned n_drop = 0;
    bit en_v = 1'b1;
    wshb.ack = 1'b1;
    for (int unsigned c = 0; c < 600; c++) begin
      @(negedge CLK);
      n_tests++;
      if ({wshb.cyc, wshb.stb, wshb.we, frame_done} !== {m_tenure, m_tenure, m_tenure, m_fd}) begin
        n_fail++;
        $display("FAIL endrop_ctrl@%0d: cyc/stb/we/fd=%b%b%b%b want %b%b%b%b", c,
                 wshb.cyc, wshb.stb, wshb.we, frame_done, m_tenure, m_tenure, m_tenure, m_fd);
      end
      if (m_tenure) begin
        n_tests++;
        if (wshb.adr !== exp_adr(m_n) || wshb.dat_ms !== exp_dat(m_n, m_f)) begin
          n_fail++;
          $display("FAIL endrop_data@%0d: adr=%0d dat=%h want %0d %h", c, wshb.adr, wshb.dat_ms,
                   exp_adr(m_n), exp_dat(m_n, m_f));
        end
      end
      if (phase == 0 && m_tenure && m_b == 10) begin
        phase = 1; en_v = 1'b0; n_drop = m_n;
      end
      if (phase == 1) begin
        cnt++;
        if (wshb.cyc === 1'b1) writes++;
        else                   lows++;
        if (cnt == 64) begin
          n_tests++;
          if (writes != 54 || lows != 10) begin
            n_fail++;
            $display("FAIL endrop_drain: writes=%0d low=%0d want 54 10", writes, lows);
          end
          phase = 2; en_v = 1'b1;
        end
      end else if (phase == 2) begin
        n_tests++;
        if (wshb.cyc !== 1'b1 || wshb.adr !== exp_adr((n_drop + 54) % FRAME)) begin
          n_fail++;
          $display("FAIL endrop_resume: cyc=%b adr=%0d want 1 %0d", wshb.cyc, wshb.adr,
                   exp_adr((n_drop + 54) % FRAME));
        end
        phase = 3;
      end
      EN = en_v;
      model_edge(1'b1, en_v);
      if (phase == 3) break;
    end
    if (phase != 3) begin
      n_tests++; n_fail++;
      $display("FAIL endrop_timeout: phase=%0d want 3", phase);
    end
  endtask

  task automatic test_reset_midburst();
    bit got = 0;
    EN = 1'b1; wshb.ack = 1'b1;
    for (int unsigned c = 0; c < 300; c++) begin
      @(negedge CLK);
      if (m_tenure && m_b >= 5) got = 1;
      model_edge(1'b1, 1'b1);
      if (got) break;
    end
    n_tests++;
    if (!got || wshb.cyc !== 1'b1) begin
      n_fail++;
      $display("FAIL midburst_setup: cyc=%b want 1", wshb.cyc);
    end
    @(posedge CLK);
    #2 RST = 1'b1;
    #1;
    n_tests++;
    if ({wshb.cyc, wshb.stb, wshb.we, frame_done} !== 4'b0000 || wshb.adr !== 32'd0 ||
        wshb.dat_ms !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_reset: cyc/stb/we/fd=%b%b%b%b adr=%0d dat=%h want 0000 0 0000",
               wshb.cyc, wshb.stb, wshb.we, frame_done, wshb.adr, wshb.dat_ms);
    end
    test_startup();
  endtask

  initial begin
    test_reset();
    test_startup();
    test_ack_stall();
    test_random_frame();
    test_en_drop();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
